// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-step shift controller: operand sizing, shifter codes
// and controller state encodings (also used by the shifter and the CPU control FSM).
package shift_sequencer_pkg;

    localparam int REG_SIZE = 16;
    localparam int AMT_W    = 4;

    typedef enum logic [1:0] {
        SHIFT_NO         = 2'b00,
        SHIFT_LEFT_ZERO  = 2'b01,
        SHIFT_RIGHT_ZERO = 2'b10,
        SHIFT_RIGHT_COPY = 2'b11
    } shift_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Combinational 1-bit shifter datapath; one position per evaluation according to the shift code.
module shift_sequencer_shifter #(
    parameter int W = shift_sequencer_pkg::REG_SIZE
) (
    input  logic [W-1:0]                    in,
    input  shift_sequencer_pkg::shift_code_t shift,
    output logic [W-1:0]                    out
);
    import shift_sequencer_pkg::*;

    // Right sign-copy keeps the MSB in place so repeated steps smear the sign bit downward.
    always_comb begin
        out = in;
        case (shift)
            SHIFT_NO:         out = in;
            SHIFT_LEFT_ZERO:  out = {in[W-2:0], 1'b0};
            SHIFT_RIGHT_ZERO: out = {1'b0, in[W-1:1]};
            SHIFT_RIGHT_COPY: out = {in[W-1], in[W-1:1]};
            default:          out = in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: latches a job on start, applies one 1-bit shift per clock
// through the shared shifter, then pulses done for one cycle and holds the result.
module shift_sequencer #(
    parameter int REG_SIZE = shift_sequencer_pkg::REG_SIZE,
    parameter int AMT_W    = shift_sequencer_pkg::AMT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [REG_SIZE-1:0] in,
    input  logic [1:0]          shift,
    input  logic [AMT_W-1:0]    amount,
    input  logic                abort,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [REG_SIZE-1:0] out
);
    import shift_sequencer_pkg::*;

    state_t              state;
    logic [AMT_W-1:0]    count;
    shift_code_t         code;
    logic [REG_SIZE-1:0] shifted;

    shift_sequencer_shifter #(
        .W(REG_SIZE)
    ) u_shifter (
        .in   (out),
        .shift(code),
        .out  (shifted)
    );

    // IDLE and DONE share acceptance logic so a start in the DONE cycle chains jobs back to back;
    // abort always beats start. A zero amount or no-shift code goes straight to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            out   <= '0;
            count <= '0;
            code  <= SHIFT_NO;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (abort || !start) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else begin
                        out   <= in;
                        count <= amount;
                        code  <= shift_code_t'(shift);
                        if (amount == '0 || shift_code_t'(shift) == SHIFT_NO) begin
                            state <= ST_DONE;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                            ready <= 1'b0;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else begin
                        out   <= shifted;
                        count <= count - AMT_W'(1);
                        if (count == AMT_W'(1)) begin
                            state <= ST_DONE;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: reset, shift modes, latency, busy-start, back-to-back, abort.
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] in;
    logic [1:0]  shift;
    logic [3:0]  amount;
    logic        abort;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] out;

    int checks;
    int failures;

    shift_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in    (in),
        .shift (shift),
        .amount(amount),
        .abort (abort),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called 1ns after an edge; returns 1ns after the accepting edge k.
    task automatic start_job(input logic [15:0] v, input logic [1:0] s, input logic [3:0] n);
        in     = v;
        shift  = s;
        amount = n;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after edge k until done is seen, bounded so a stuck DUT cannot hang the run.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        checks++;
        if (out !== 16'h0000 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: out=%h ready=%b busy=%b done=%b, need 0000 1 0 0", out, ready, busy, done);
        end
        start_job(16'h1234, 2'b01, 4'd5);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || out !== 16'h48D0) begin
            failures++;
            $display("[TB] FAIL reset_pre: busy=%b out=%h, need 1 48d0", busy, out);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (out !== 16'h0000 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid: out=%h ready=%b busy=%b done=%b, need 0000 1 0 0", out, ready, busy, done);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out !== 16'h0000 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_after: out=%h done=%b, need 0000 0", out, done);
        end
    endtask

    task automatic test_left_shift;
        int bc;
        bc = 0;
        start_job(16'h0001, 2'b01, 4'd4);
        for (int i = 0; i < 4; i++) begin
            if (busy === 1'b1 && done === 1'b0) bc++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bc !== 4) begin
            failures++;
            $display("[TB] FAIL left_busy_cycles: got %0d, need 4", bc);
        end
        checks++;
        if (done !== 1'b1 || out !== 16'h0010 || ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL left_done: done=%b out=%h ready=%b, need 1 0010 1", done, out, ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || out !== 16'h0010 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL left_hold: done=%b out=%h busy=%b, need 0 0010 0", done, out, busy);
        end
    endtask

    task automatic test_max_amount;
        int n;
        start_job(16'h8000, 2'b11, 4'd15);
        wait_done(n);
        checks++;
        if (n !== 15 || out !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL sign_copy_15: latency=%0d out=%h, need 15 ffff", n, out);
        end
        @(posedge clk);
        #1;
        start_job(16'h8000, 2'b10, 4'd15);
        wait_done(n);
        checks++;
        if (n !== 15 || out !== 16'h0001) begin
            failures++;
            $display("[TB] FAIL right_zero_15: latency=%0d out=%h, need 15 0001", n, out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_work;
        int n;
        start_job(16'hBEEF, 2'b01, 4'd0);
        wait_done(n);
        checks++;
        if (n !== 0 || out !== 16'hBEEF || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL amount_zero: latency=%0d out=%h busy=%b, need 0 beef 0", n, out, busy);
        end
        @(posedge clk);
        #1;
        start_job(16'hA5A5, 2'b00, 4'd7);
        wait_done(n);
        checks++;
        if (n !== 0 || out !== 16'hA5A5) begin
            failures++;
            $display("[TB] FAIL shift_none: latency=%0d out=%h, need 0 a5a5", n, out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_while_busy;
        int n;
        start_job(16'h0003, 2'b01, 4'd3);
        in     = 16'hFFFF;
        shift  = 2'b10;
        amount = 4'd1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 2 || out !== 16'h0018) begin
            failures++;
            $display("[TB] FAIL busy_start_ignored: latency_rest=%0d out=%h, need 2 0018", n, out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out !== 16'h0018) begin
            failures++;
            $display("[TB] FAIL busy_start_after: done=%b busy=%b out=%h, need 0 0 0018", done, busy, out);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        start_job(16'h0001, 2'b01, 4'd2);
        wait_done(n);
        checks++;
        if (n !== 2 || out !== 16'h0004) begin
            failures++;
            $display("[TB] FAIL b2b_first: latency=%0d out=%h, need 2 0004", n, out);
        end
        start_job(16'h0100, 2'b10, 4'd3);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || out !== 16'h0100) begin
            failures++;
            $display("[TB] FAIL b2b_accept: done=%b busy=%b out=%h, need 0 1 0100", done, busy, out);
        end
        wait_done(n);
        checks++;
        if (n !== 3 || out !== 16'h0020) begin
            failures++;
            $display("[TB] FAIL b2b_second: latency=%0d out=%h, need 3 0020", n, out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_abort;
        int pulses;
        pulses = 0;
        start_job(16'h00F0, 2'b10, 4'd6);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0 || out !== 16'h003C) begin
            failures++;
            $display("[TB] FAIL abort_state: busy=%b ready=%b done=%b out=%h, need 0 1 0 003c", busy, ready, done, out);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || out !== 16'h003C) begin
            failures++;
            $display("[TB] FAIL abort_quiet: done_pulses=%0d out=%h, need 0 003c", pulses, out);
        end
        abort = 1'b1;
        start_job(16'h1111, 2'b01, 4'd1);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h003C) begin
            failures++;
            $display("[TB] FAIL abort_beats_start: busy=%b done=%b out=%h, need 0 0 003c", busy, done, out);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        in       = '0;
        shift    = 2'b00;
        amount   = '0;
        abort    = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_left_shift();
        test_max_amount();
        test_zero_work();
        test_start_while_busy();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
